// File: rtl/pmcc_trigger_unit_if.sv
// -----------------------------------------------------------------------------
// pmcc_trigger_unit_if
// Signal bundle between the wait controller (master) and the trigger unit
// (slave). Clock and reset are not part of the bundle.
//
//   waitt         master->slave  coprocessor wait instruction active
//   mode[1:0]     master->slave  00 ext rise, 01 ext fall, 10 ext level-high, 11 timeout
//   timeout[N-1:0]master->slave  wait length in clk cycles for mode 11
//   ext_trigger   master->slave  asynchronous external event pin
//   trigger       slave->master  registered release strobe
//   armed         slave->master  unit is waiting for its event
//   trigger_count slave->master  saturating count of fired triggers
// -----------------------------------------------------------------------------
interface pmcc_trigger_unit_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 waitt;
  logic [1:0]           mode;
  logic [CNT_WIDTH-1:0] timeout;
  logic                 ext_trigger;
  logic                 trigger;
  logic                 armed;
  logic [7:0]           trigger_count;

  modport master (
    output waitt, mode, timeout, ext_trigger,
    input  trigger, armed, trigger_count
  );

  modport slave (
    input  waitt, mode, timeout, ext_trigger,
    output trigger, armed, trigger_count
  );
endinterface

// File: rtl/pmcc_trigger_unit.sv
// -----------------------------------------------------------------------------
// pmcc_trigger_unit
// Releases a coprocessor wait instruction when a selected event occurs:
// a synchronised edge or level on ext_trigger, or expiry of a cycle timeout.
// The wait controller computes waiting = waitt & ~trigger.
//
// Ports:
//   clk    single block clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pmcc_trigger_unit_if.slave (waitt, mode, timeout, ext_trigger in;
//          trigger, armed, trigger_count out)
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on ext_trigger (min 2)
//   CNT_WIDTH    width of timeout input and internal counter
//
// Optional feature (macro PMCC_TRIGGER_PENDING_EN):
//   An edge matching the mode input (00 rise, 01 fall) seen while IDLE is
//   remembered; the next arming then fires one cycle after the arming edge.
//   Without the macro, events outside ARMED are discarded.
// -----------------------------------------------------------------------------
module pmcc_trigger_unit #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  pmcc_trigger_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FIRED = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                  r_s_d;
  logic [1:0]            r_mode_q;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [7:0]            r_count;

  logic w_s;
  logic w_rise;
  logic w_fall;
  logic w_event;
  logic w_arm;
  logic w_fire;

  // Synchronizer output and edge detection against one extra delayed copy.
  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise =  w_s & ~r_s_d;
  assign w_fall = ~w_s &  r_s_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.ext_trigger};
      r_s_d  <= w_s;
    end
  end

`ifdef PMCC_TRIGGER_PENDING_EN
  // r_pending remembers a mode-matching edge seen in IDLE; r_prearm carries it
  // into ARMED so the unit fires on the edge after arming.
  logic r_pending;
  logic r_prearm;
  logic w_idle_edge;

  assign w_idle_edge = (r_state == S_IDLE) &&
                       (((bus.mode == 2'b00) && w_rise) ||
                        ((bus.mode == 2'b01) && w_fall));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_prearm  <= 1'b0;
    end else begin
      if (w_arm) begin
        r_pending <= 1'b0;
        r_prearm  <= r_pending | w_idle_edge;
      end else begin
        if (w_idle_edge) r_pending <= 1'b1;
        if (r_state != S_ARMED) r_prearm <= 1'b0;
      end
      if (w_next != S_ARMED) r_prearm <= 1'b0;
    end
  end
`endif

  // Event selected by the mode captured at arming time.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    w_event = 1'b0;
    unique case (r_mode_q)
      2'b00:   w_event = w_rise;
      2'b01:   w_event = w_fall;
      2'b10:   w_event = w_s;
      default: w_event = (r_cnt <= CNT_WIDTH'(1));
    endcase
`ifdef PMCC_TRIGGER_PENDING_EN
    w_event = w_event | r_prearm;
`endif
  end

  // Next state: abort (waitt low) has priority over a simultaneous event.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.waitt) w_next = S_ARMED;
      S_ARMED: begin
        if (!bus.waitt)   w_next = S_IDLE;
        else if (w_event) w_next = S_FIRED;
      end
      S_FIRED: if (!bus.waitt) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_arm  = (r_state == S_IDLE)  && (w_next == S_ARMED);
  assign w_fire = (r_state == S_ARMED) && (w_next == S_FIRED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mode_q <= 2'b00;
      r_cnt    <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_next;
      // mode and timeout are only sampled on the arming edge.
      if (w_arm) begin
        r_mode_q <= bus.mode;
        r_cnt    <= bus.timeout;
      end else if ((r_state == S_ARMED) && (r_mode_q == 2'b11) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_WIDTH'(1);
      end
      if (w_fire && (r_count != 8'hFF)) r_count <= r_count + 8'd1;
    end
  end

  assign bus.trigger       = (r_state == S_FIRED);
  assign bus.armed         = (r_state == S_ARMED);
  assign bus.trigger_count = r_count;

endmodule

// File: tb/tb_pmcc_trigger_unit.sv
// -----------------------------------------------------------------------------
// tb_pmcc_trigger_unit
// Directed stimulus for pmcc_trigger_unit. Each expected trigger (cycle of the
// rising edge and trigger_count at that point) is queued when the stimulus is
// issued; a monitor on the falling clock edge pops and compares whenever the
// DUT raises trigger. An unexpected trigger or a leftover entry is a failure.
// Build with +define+PMCC_TRIGGER_PENDING_EN to exercise the pending feature.
// -----------------------------------------------------------------------------
module tb_pmcc_trigger_unit;

  localparam int SYNC = 2;
  localparam int CW   = 16;

  typedef struct {
    string name;
    int    cyc;
    int    cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass  = 0;
  logic prev_trig = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  pmcc_trigger_unit_if #(.CNT_WIDTH(CW)) bus ();

  pmcc_trigger_unit #(
    .SYNC_STAGES(SYNC),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_fire(input string name, input int c, input int cnt);
    exp_t e;
    e.name = name;
    e.cyc  = c;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic arm(input logic [1:0] m, input logic [CW-1:0] t, output int a);
    bus.waitt   = 1'b1;
    bus.mode    = m;
    bus.timeout = t;
    tick(1);
    a = cyc;
  endtask

  // Monitor: compare each trigger rising edge against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.trigger && !prev_trig) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_trigger: trigger rose at cycle %0d, expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
        check({mon_e.name, "_count"}, int'(bus.trigger_count), mon_e.cnt);
      end
    end
    prev_trig = bus.trigger;
  end

  initial begin
    int a;
    int p;
    rst_n           = 1'b0;
    bus.waitt       = 1'b0;
    bus.mode        = 2'b11;
    bus.timeout     = '0;
    bus.ext_trigger = 1'b0;

    // Reset state
    tick(3);
    check("reset_trigger", bus.trigger, 0);
    check("reset_armed", bus.armed, 0);
    check("reset_count", bus.trigger_count, 0);
    rst_n = 1'b1;
    tick(4);

    // Mode 00: rising edge fires SYNC+1 edges after the pin change
    arm(2'b00, '0, a);
    tick(2);
    check("m00_armed", bus.armed, 1);
    bus.ext_trigger = 1'b1;
    p = cyc;
    expect_fire("m00", p + SYNC + 1, 1);
    tick(5);
    bus.ext_trigger = 1'b0;
    tick(4);
    bus.ext_trigger = 1'b1;          // second edge while FIRED must not retrigger
    tick(4);
    check("m00_hold", bus.trigger, 1);
    bus.ext_trigger = 1'b0;
    tick(3);
    bus.waitt = 1'b0;
    tick(1);
    check("m00_release_trigger", bus.trigger, 0);
    check("m00_release_armed", bus.armed, 0);
    tick(2);
    bus.mode = 2'b11;

    // Mode 11, timeout 10; input changes while ARMED are ignored
    arm(2'b11, CW'(10), a);
    expect_fire("m11_t10", a + 10, 2);
    tick(1);
    bus.mode    = 2'b00;
    bus.timeout = CW'(1);
    tick(12);
    bus.waitt = 1'b0;
    bus.mode  = 2'b11;
    tick(2);

    // Mode 11, timeout 0: fires one cycle after arming
    arm(2'b11, CW'(0), a);
    expect_fire("m11_t0", a + 1, 3);
    tick(3);
    bus.waitt = 1'b0;
    tick(2);

    // Mode 01: waitt dropped in the cycle the fall is detected -> abort
    bus.ext_trigger = 1'b1;
    tick(4);
    arm(2'b01, '0, a);
    tick(1);
    bus.ext_trigger = 1'b0;
    tick(2);
    check("m01_armed_before_fall", bus.armed, 1);
    bus.waitt = 1'b0;
    tick(1);
    check("m01_abort_trigger", bus.trigger, 0);
    check("m01_abort_armed", bus.armed, 0);
    check("m01_abort_count", bus.trigger_count, 3);
    bus.mode = 2'b11;
    tick(3);

    // Mode 10 with pin already high: fires one cycle after arming
    bus.ext_trigger = 1'b1;
    tick(4);
    arm(2'b10, '0, a);
    expect_fire("m10_level", a + 1, 4);
    tick(1);
    bus.waitt = 1'b0;
    tick(1);
    check("m10_idle", bus.armed, 0);

    // Saturation: 300 more arm/fire cycles
    for (int i = 0; i < 300; i++) begin
      arm(2'b10, '0, a);
      expect_fire("sat", a + 1, (5 + i > 255) ? 255 : 5 + i);
      tick(1);
      bus.waitt = 1'b0;
      tick(1);
    end
    check("sat_count", bus.trigger_count, 255);
    bus.mode        = 2'b11;
    bus.ext_trigger = 1'b0;
    tick(4);

    // Reset asserted while ARMED abandons the wait
    arm(2'b11, CW'(100), a);
    tick(3);
    check("rst_pre_armed", bus.armed, 1);
    #2;
    rst_n     = 1'b0;
    bus.waitt = 1'b0;
    #1;
    check("rst_async_trigger", bus.trigger, 0);
    check("rst_async_armed", bus.armed, 0);
    check("rst_async_count", bus.trigger_count, 0);
    tick(2);
    rst_n = 1'b1;
    tick(120);
    check("rst_after_armed", bus.armed, 0);
    check("rst_after_count", bus.trigger_count, 0);
    arm(2'b11, CW'(5), a);
    expect_fire("rst_rearm", a + 5, 1);
    tick(7);
    bus.waitt = 1'b0;
    tick(2);

    // Rising edge in IDLE, then arm in mode 00
    bus.mode        = 2'b00;
    bus.ext_trigger = 1'b1;
    tick(4);
    arm(2'b00, '0, a);
`ifdef PMCC_TRIGGER_PENDING_EN
    expect_fire("pending", a + 1, 2);
    tick(4);
`else
    tick(4);
    check("nopend_armed", bus.armed, 1);
    check("nopend_trigger", bus.trigger, 0);
    bus.ext_trigger = 1'b0;
    tick(4);
    bus.ext_trigger = 1'b1;
    p = cyc;
    expect_fire("nopend_new_edge", p + SYNC + 1, 2);
    tick(5);
`endif
    bus.waitt = 1'b0;
    tick(5);

    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_total++;
      $display("FAIL missing_trigger %s: no trigger seen, expected at cycle %0d", mon_e.name, mon_e.cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
